led_breathe: RTL and testbench

Single-channel LED "breathing" driver fed by the periodic tick strobe of a timer stage. Each tick steps an internal duty value up or down through a four-state ramp/hold cycle. A free-running PWM generator converts that duty into a glitch-free LED drive. It sits between a timer instance and one `led` bit at the demo top level.

---
 rtl/led_breathe.sv | 103 ++++++++++
 tb/tb_led_breathe.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/led_breathe.sv
// Single-channel LED breathing driver: a tick-stepped ramp/hold duty FSM
// feeding a free-running PWM whose compare value only changes at period boundaries.
module led_breathe #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  output logic             pwm,
  output logic [WIDTH-1:0] duty,
  output logic [1:0]       phase
);

  localparam logic [WIDTH-1:0] MAX    = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam int               HW     = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'((HOLD > 0) ? HOLD - 1 : 0);

  localparam logic [1:0] UP      = 2'd0;
  localparam logic [1:0] HOLD_HI = 2'd1;
  localparam logic [1:0] DOWN    = 2'd2;
  localparam logic [1:0] HOLD_LO = 2'd3;

  // With HOLD == 0 the hold states are skipped entirely.
  localparam logic [1:0] AFTER_PEAK   = (HOLD > 0) ? HOLD_HI : DOWN;
  localparam logic [1:0] AFTER_TROUGH = (HOLD > 0) ? HOLD_LO : UP;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act;
  logic [HW-1:0]    hold;

  logic [WIDTH-1:0] duty_nxt;
  logic [1:0]       phase_nxt;
  logic [HW-1:0]    hold_nxt;
  logic [WIDTH:0]   sum;
  logic             boundary;

  assign sum      = {1'b0, duty} + STEP_X;
  assign boundary = (cnt == MAX - 1'b1);

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    duty_nxt  = duty;
    phase_nxt = phase;
    hold_nxt  = hold;
    if (tick && en) begin
      case (phase)
        UP: begin
          if (sum >= {1'b0, MAX}) begin
            duty_nxt  = MAX;
            phase_nxt = AFTER_PEAK;
          end else begin
            duty_nxt = sum[WIDTH-1:0];
          end
        end
        HOLD_HI, HOLD_LO: begin
          if (hold == HOLD_LAST) begin
            hold_nxt  = '0;
            phase_nxt = (phase == HOLD_HI) ? DOWN : UP;
          end else begin
            hold_nxt = hold + 1'b1;
          end
        end
        DOWN: begin
          if (duty <= STEP_V) begin
            duty_nxt  = '0;
            phase_nxt = AFTER_TROUGH;
          end else begin
            duty_nxt = duty - STEP_V;
          end
        end
        default: phase_nxt = UP;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      act   <= '0;
      pwm   <= 1'b0;
      duty  <= '0;
      phase <= UP;
      hold  <= '0;
    end else begin
      cnt <= boundary ? '0 : cnt + 1'b1;
      // act only moves at the period boundary so pwm never glitches mid-period.
      if (boundary) act <= duty;
      pwm   <= en && (cnt < act);
      duty  <= duty_nxt;
      phase <= phase_nxt;
      hold  <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe: a vector table for the ramp/hold sequence
// plus hand-written sequences for PWM shape, boundary ticks, reset and enable.
module tb_led_breathe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       tick_a;
  logic       tick_b;
  logic       pwm_a, pwm_b;
  logic [3:0] duty_a, duty_b;
  logic [1:0] phase_a, phase_b;

  int n_vec = 0;
  int n_bad = 0;
  int ecount = 0;

  always #5 clk = ~clk;

  led_breathe #(.WIDTH(4), .STEP(5), .HOLD(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .tick(tick_a), .en(en),
    .pwm(pwm_a), .duty(duty_a), .phase(phase_a)
  );

  led_breathe #(.WIDTH(4), .STEP(4), .HOLD(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .tick(tick_b), .en(en),
    .pwm(pwm_b), .duty(duty_b), .phase(phase_b)
  );

  typedef struct {
    logic rst_n;
    logic tick;
    logic en;
    int   duty_a;
    int   phase_a;
    int   duty_b;
    int   phase_b;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // One clock edge; ecount counts edges since the last reset edge.
  task automatic step();
    @(posedge clk);
    if (!rst_n) ecount = 0;
    else ecount++;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick_a = 1'b0; tick_b = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic ticks_a(input int n);
    for (int i = 0; i < n; i++) begin
      tick_a = 1'b1;
      step();
    end
    tick_a = 1'b0;
  endtask

  // Advance to the next edge at which act reloads (cnt was MAX-1).
  task automatic run_to_load();
    step();
    while (ecount % 15 != 0) step();
  endtask

  // Called right after a load edge: checks the next 15 pwm samples.
  task automatic check_period(input int hi, input string name);
    for (int k = 0; k < 15; k++) begin
      step();
      check($sformatf("%s pwm k=%0d", name, k), int'(pwm_a), (k < hi) ? 1 : 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; tick_a = 1'b0; tick_b = 1'b0;

    //           rst   tick  en    dA  pA  dB  pB
    vecs[0]  = '{1'b0, 1'b0, 1'b1,  0, 0,  0, 0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1,  5, 0,  4, 0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 10, 0,  8, 0};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 15, 1, 12, 0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 15, 1, 15, 1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 15, 2, 15, 1};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 10, 2, 15, 2};
    vecs[7]  = '{1'b1, 1'b1, 1'b1,  5, 2, 11, 2};
    vecs[8]  = '{1'b1, 1'b1, 1'b1,  0, 3,  7, 2};
    vecs[9]  = '{1'b1, 1'b1, 1'b1,  0, 3,  3, 2};
    vecs[10] = '{1'b1, 1'b1, 1'b1,  0, 0,  0, 3};
    vecs[11] = '{1'b1, 1'b1, 1'b0,  0, 0,  0, 3};
    vecs[12] = '{1'b1, 1'b0, 1'b1,  0, 0,  0, 3};
    vecs[13] = '{1'b1, 1'b1, 1'b1,  5, 0,  0, 3};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 10, 0,  0, 0};

    for (int i = 0; i < 15; i++) begin
      rst_n = vecs[i].rst_n; tick_a = vecs[i].tick; tick_b = vecs[i].tick; en = vecs[i].en;
      step();
      check($sformatf("vec%0d duty_a", i), int'(duty_a), vecs[i].duty_a);
      check($sformatf("vec%0d phase_a", i), int'(phase_a), vecs[i].phase_a);
      check($sformatf("vec%0d duty_b", i), int'(duty_b), vecs[i].duty_b);
      check($sformatf("vec%0d phase_b", i), int'(phase_b), vecs[i].phase_b);
      if (i == 0) check("vec0 pwm_a", int'(pwm_a), 0);
    end
    rst_n = 1'b1; tick_a = 1'b0; tick_b = 1'b0; en = 1'b1;

    // PWM shape: duty 5 for two periods, then 15, then 0.
    do_reset();
    ticks_a(1);
    run_to_load();
    check_period(5, "shape5a");
    check_period(5, "shape5b");
    ticks_a(2);
    check("shape duty15", int'(duty_a), 15);
    run_to_load();
    check_period(15, "shape15");
    ticks_a(5);
    check("shape duty0", int'(duty_a), 0);
    check("shape phase3", int'(phase_a), 3);
    run_to_load();
    check_period(0, "shape0");

    // Reset mid-ramp and mid-period, held low for three edges.
    do_reset();
    ticks_a(6);
    check("rst pre duty", int'(duty_a), 10);
    check("rst pre phase", int'(phase_a), 2);
    run_to_load();
    step(); step();
    check("rst pre pwm", int'(pwm_a), 1);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst%0d duty", i), int'(duty_a), 0);
      check($sformatf("rst%0d phase", i), int'(phase_a), 0);
      check($sformatf("rst%0d pwm", i), int'(pwm_a), 0);
    end
    rst_n = 1'b1;
    ticks_a(1);
    run_to_load();
    check_period(5, "post-rst");

    // Tick coincident with the period boundary.
    do_reset();
    ticks_a(1);
    while (ecount < 14) step();
    ticks_a(1);
    check("bnd duty", int'(duty_a), 10);
    check_period(5, "bnd old");
    check_period(10, "bnd new");

    // Enable low for 40 cycles with three ticks, then one enabled tick.
    en = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick_a = (c == 5 || c == 20 || c == 33);
      step();
      check($sformatf("en0 c%0d pwm", c), int'(pwm_a), 0);
      check($sformatf("en0 c%0d duty", c), int'(duty_a), 10);
      check($sformatf("en0 c%0d phase", c), int'(phase_a), 0);
    end
    tick_a = 1'b0;
    en = 1'b1;
    ticks_a(1);
    check("en1 duty", int'(duty_a), 15);
    check("en1 phase", int'(phase_a), 1);
    step();
    check("en1 duty hold", int'(duty_a), 15);
    check("en1 phase hold", int'(phase_a), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
